// File: rtl/udp_rx_deframer.sv
// udp_rx_deframer
//
// Receives Ethernet frames from a 512-bit AXI-Stream MAC interface. It keeps
// only IPv4/UDP frames addressed to this node, strips the 42-byte
// Ethernet/IPv4/UDP header and re-aligns the payload so that payload byte 0
// lands in udp_rx_data[7:0].
//
// Handshake: neither stream has a ready signal. A beat moves on every rising
// edge where its valid is high, so input beats can never be stalled. Every
// emitted output beat is valid for exactly one cycle.
//
// Re-alignment: the header ends at byte 42 of the first beat. Bytes 42..63 of
// each beat (22 bytes) are held back as a residual. They are prepended to the
// first 42 bytes of the following beat. If the last beat carries more than
// 42 bytes, the leftover residual goes out one cycle later as a flush beat.
//
// Ports
//   axis_rx_clkin      sole clock, rising edge
//   axis_rx_resetn     synchronous active-low reset
//   Enable             accept packets; sampled on the first beat only
//   fabric_mac/ip/port destination match values (quasi-static)
//   axis_rx_t*         input AXI-Stream; tuser = error flag on the last beat
//   udp_rx_data/keep   re-aligned payload; bytes with keep = 0 are zero
//   udp_rx_valid       output beat strobe
//   udp_rx_eof         last payload beat of a packet
//   udp_rx_bad         MAC error flag of that packet (on eof beats only)
//   udp_rx_pkt_count   packets delivered (counts eof beats), wraps
//   udp_rx_drop_count  packets rejected by the header match, wraps
//   fsm_state          debug view of the control state

module udp_rx_deframer (
  input  logic         axis_rx_clkin,
  input  logic         axis_rx_resetn,
  input  logic         Enable,
  input  logic [47:0]  fabric_mac,
  input  logic [31:0]  fabric_ip,
  input  logic [15:0]  fabric_port,
  input  logic [511:0] axis_rx_tdata,
  input  logic [63:0]  axis_rx_tkeep,
  input  logic         axis_rx_tvalid,
  input  logic         axis_rx_tlast,
  input  logic         axis_rx_tuser,
  output logic [511:0] udp_rx_data,
  output logic [63:0]  udp_rx_keep,
  output logic         udp_rx_valid,
  output logic         udp_rx_eof,
  output logic         udp_rx_bad,
  output logic [31:0]  udp_rx_pkt_count,
  output logic [31:0]  udp_rx_drop_count,
  output logic [2:0]   fsm_state
);

  // SYNC  : out of reset, discarding until the first tlast
  // IDLE  : waiting for a first beat
  // PASS  : inside an accepted packet
  // DROP  : inside a rejected packet
  // FLUSH : emitting the residual tail; a valid beat here is a new first beat
  localparam logic [2:0] ST_SYNC  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_PASS  = 3'd2;
  localparam logic [2:0] ST_DROP  = 3'd3;
  localparam logic [2:0] ST_FLUSH = 3'd4;

  logic [2:0]   state;
  logic [175:0] residual;    // 22 held-back bytes, byte 0 in [7:0]
  logic [4:0]   flush_len;   // bytes in the pending flush beat, 1..22
  logic         flush_bad;   // tuser captured with the last input beat

  logic [6:0]   beat_len;    // n = number of set tkeep bits, 0..64
  logic [511:0] data_m;      // input data with bytes beyond n zeroed
  logic [47:0]  hdr_mac;
  logic [15:0]  hdr_ethertype;
  logic [7:0]   hdr_ver_ihl;
  logic [7:0]   hdr_proto;
  logic [31:0]  hdr_ip;
  logic [15:0]  hdr_port;
  logic         hdr_match;
  logic [6:0]   pass_keep_len;

  assign fsm_state = state;

  // Low k bits set; k = 64 gives all ones.
  function automatic logic [63:0] low_ones(input logic [6:0] k);
    if (k >= 7'd64) low_ones = '1;
    else            low_ones = (64'd1 << k) - 64'd1;
  endfunction

  always_comb begin
    beat_len = '0;
    for (int i = 0; i < 64; i++) begin
      beat_len = beat_len + 7'(axis_rx_tkeep[i]);
    end
  end

  // Masking the input here keeps unused output bytes zero. This holds both
  // for pass-through beats and for the residual that later feeds a flush beat.
  always_comb begin
    data_m = '0;
    for (int i = 0; i < 64; i++) begin
      if (beat_len > 7'(i)) data_m[8*i +: 8] = axis_rx_tdata[8*i +: 8];
    end
  end

  // Header fields are big-endian on the wire: the lowest byte index is the MSB.
  assign hdr_mac       = {data_m[7:0],   data_m[15:8],  data_m[23:16],
                          data_m[31:24], data_m[39:32], data_m[47:40]};
  assign hdr_ethertype = {data_m[103:96], data_m[111:104]};
  assign hdr_ver_ihl   = data_m[119:112];
  assign hdr_proto     = data_m[191:184];
  assign hdr_ip        = {data_m[247:240], data_m[255:248],
                          data_m[263:256], data_m[271:264]};
  assign hdr_port      = {data_m[295:288], data_m[303:296]};

  // Only options-free IPv4 (0x45) carrying UDP (0x11) is accepted. The first
  // beat must also hold the whole header plus at least one payload byte.
  assign hdr_match = Enable
                  && (hdr_mac == fabric_mac)
                  && (hdr_ethertype == 16'h0800)
                  && (hdr_ver_ihl == 8'h45)
                  && (hdr_proto == 8'h11)
                  && (hdr_ip == fabric_ip)
                  && (hdr_port == fabric_port)
                  && (beat_len >= 7'd43);

  // A pass beat carries the 22 residual bytes plus up to 42 new bytes.
  assign pass_keep_len = (beat_len > 7'd42) ? 7'd64 : (beat_len + 7'd22);

  always_ff @(posedge axis_rx_clkin) begin
    if (!axis_rx_resetn) begin
      state             <= ST_SYNC;
      residual          <= '0;
      flush_len         <= '0;
      flush_bad         <= 1'b0;
      udp_rx_data       <= '0;
      udp_rx_keep       <= '0;
      udp_rx_valid      <= 1'b0;
      udp_rx_eof        <= 1'b0;
      udp_rx_bad        <= 1'b0;
      udp_rx_pkt_count  <= '0;
      udp_rx_drop_count <= '0;
    end else begin
      // Nothing is emitted unless one of the branches below says so.
      udp_rx_valid <= 1'b0;
      udp_rx_eof   <= 1'b0;
      udp_rx_bad   <= 1'b0;
      udp_rx_data  <= '0;
      udp_rx_keep  <= '0;

      // The flush beat goes out on every FLUSH edge, whether or not a new
      // first beat arrives in the same cycle. First beats never emit, so the
      // two never compete for the output register.
      if (state == ST_FLUSH) begin
        udp_rx_valid     <= 1'b1;
        udp_rx_data      <= {336'd0, residual};
        udp_rx_keep      <= low_ones({2'b00, flush_len});
        udp_rx_eof       <= 1'b1;
        udp_rx_bad       <= flush_bad;
        udp_rx_pkt_count <= udp_rx_pkt_count + 32'd1;
      end

      case (state)
        ST_SYNC: begin
          if (axis_rx_tvalid && axis_rx_tlast) state <= ST_IDLE;
        end

        ST_DROP: begin
          if (axis_rx_tvalid && axis_rx_tlast) begin
            state             <= ST_IDLE;
            udp_rx_drop_count <= udp_rx_drop_count + 32'd1;
          end
        end

        ST_PASS: begin
          if (axis_rx_tvalid) begin
            udp_rx_valid <= 1'b1;
            udp_rx_data  <= {data_m[335:0], residual};
            udp_rx_keep  <= low_ones(pass_keep_len);
            residual     <= data_m[511:336];
            if (axis_rx_tlast) begin
              if (beat_len <= 7'd42) begin
                // Everything fits in this beat; no flush needed.
                udp_rx_eof       <= 1'b1;
                udp_rx_bad       <= axis_rx_tuser;
                udp_rx_pkt_count <= udp_rx_pkt_count + 32'd1;
                state            <= ST_IDLE;
              end else begin
                flush_len <= 5'(beat_len - 7'd42);
                flush_bad <= axis_rx_tuser;
                state     <= ST_FLUSH;
              end
            end
          end
        end

        ST_IDLE, ST_FLUSH: begin
          if (axis_rx_tvalid) begin
            if (hdr_match) begin
              residual <= data_m[511:336];
              if (axis_rx_tlast) begin
                // Single-beat packet: its whole payload is the residual.
                flush_len <= 5'(beat_len - 7'd42);
                flush_bad <= axis_rx_tuser;
                state     <= ST_FLUSH;
              end else begin
                state <= ST_PASS;
              end
            end else if (axis_rx_tlast) begin
              udp_rx_drop_count <= udp_rx_drop_count + 32'd1;
              state             <= ST_IDLE;
            end else begin
              state <= ST_DROP;
            end
          end else begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_SYNC;
      endcase
    end
  end

endmodule
